dac_spi_transmisor: RTL and testbench

//  Transmit side of the serial converter link: sends filter-output samples to a 12-bit
//  SPI DAC (DAC121S101-class: 16-bit frame, SYNC low, sampled on SCLK falling edge).

---
 rtl/dac_spi_transmisor.sv | 159 +++++++++++++++
 tb/tb_dac_spi_transmisor.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_transmisor.sv
// Transmit side of the converter link: turns signed filter samples into 12-bit offset
// binary codes and streams them as 16-bit SPI frames to a DAC121S101-class DAC.
module dac_spi_transmisor #(
  parameter int unsigned Width = 22,
  parameter int unsigned SHIFT = 8,
  parameter int unsigned DIV   = 2
) (
  input  logic             clk100MHz,
  input  logic             reset,
  input  logic             inicio,
  input  logic [Width-1:0] dato,
  output logic             listo,
  output logic             ocupado,
  output logic             perdido,
  output logic             CS,
  output logic             sclk,
  output logic             sdata
);

  localparam int unsigned CW = $clog2(2 * DIV);
  localparam logic [CW-1:0] H_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] W_LAST  = CW'(2 * DIV - 1);
  localparam logic [CW-1:0] W_LISTO = CW'(2 * DIV - 2);
  localparam logic signed [Width-1:0] VMAX = Width'(2047);
  localparam logic signed [Width-1:0] VMIN = Width'(-2048);

  typedef enum logic [1:0] {IDLE, CARGA, DESPLAZA, ESPERA} state_t;

  state_t          state, state_n;
  logic [15:0]     shreg, shreg_n;
  logic            buf_valid, buf_valid_n;
  logic [11:0]     buf_code, buf_code_n;
  logic [CW-1:0]   hcnt, hcnt_n;
  logic [3:0]      bitcnt, bitcnt_n;
  logic            listo_n, ocupado_n, perdido_n, cs_n, sclk_n, sdata_n;
  logic            consume;
  logic [15:0]     frame;
  logic signed [Width-1:0] shifted;
  logic [11:0]     conv;

  // Shift, saturate to the signed 12-bit range, then flip the sign bit for offset binary
  always_comb begin
    shifted = $signed(dato) >>> SHIFT;
    if (shifted > VMAX)      conv = 12'hFFF;
    else if (shifted < VMIN) conv = 12'h000;
    else                     conv = {~shifted[11], shifted[10:0]};
  end

  assign frame = {4'b0000, buf_code};

  always_ff @(posedge clk100MHz) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      buf_valid <= 1'b0;
      buf_code  <= '0;
      hcnt      <= '0;
      bitcnt    <= '0;
      listo     <= 1'b0;
      ocupado   <= 1'b0;
      perdido   <= 1'b0;
      CS        <= 1'b1;
      sclk      <= 1'b1;
      sdata     <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      buf_valid <= buf_valid_n;
      buf_code  <= buf_code_n;
      hcnt      <= hcnt_n;
      bitcnt    <= bitcnt_n;
      listo     <= listo_n;
      ocupado   <= ocupado_n;
      perdido   <= perdido_n;
      CS        <= cs_n;
      sclk      <= sclk_n;
      sdata     <= sdata_n;
    end
  end

  // The frame load is prepared on the edge entering CARGA, so CARGA is already the
  // first high phase of bit 15 and back-to-back frames keep CS high for exactly 2*H.
  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    buf_valid_n = buf_valid;
    buf_code_n  = buf_code;
    hcnt_n      = hcnt;
    bitcnt_n    = bitcnt;
    listo_n     = 1'b0;
    ocupado_n   = ocupado;
    perdido_n   = 1'b0;
    cs_n        = CS;
    sclk_n      = sclk;
    sdata_n     = sdata;
    consume     = 1'b0;

    case (state)
      IDLE: begin
        if (buf_valid) consume = 1'b1;
      end
      CARGA, DESPLAZA: begin
        if (state == CARGA) state_n = DESPLAZA;
        if (hcnt == H_LAST) begin
          hcnt_n = '0;
          if (sclk) begin
            sclk_n = 1'b0;
          end else if (bitcnt == 4'd0) begin
            sclk_n  = 1'b1;
            cs_n    = 1'b1;
            sdata_n = 1'b0;
            state_n = ESPERA;
          end else begin
            sclk_n   = 1'b1;
            bitcnt_n = bitcnt - 4'd1;
            shreg_n  = {shreg[14:0], 1'b0};
            sdata_n  = shreg[14];
          end
        end else begin
          hcnt_n = hcnt + CW'(1);
        end
      end
      ESPERA: begin
        hcnt_n  = hcnt + CW'(1);
        listo_n = (hcnt == W_LISTO);
        if (hcnt == W_LAST) begin
          hcnt_n = '0;
          if (buf_valid) begin
            consume = 1'b1;
          end else begin
            state_n   = IDLE;
            ocupado_n = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (consume) begin
      state_n     = CARGA;
      shreg_n     = frame;
      buf_valid_n = 1'b0;
      cs_n        = 1'b0;
      sclk_n      = 1'b1;
      sdata_n     = frame[15];
      ocupado_n   = 1'b1;
      hcnt_n      = '0;
      bitcnt_n    = 4'd15;
    end

    // A new strobe always lands in the hold buffer; only a pending unconsumed entry is lost
    if (inicio) begin
      buf_code_n  = conv;
      buf_valid_n = 1'b1;
      perdido_n   = buf_valid && !consume;
    end
  end

endmodule

// File: tb/tb_dac_spi_transmisor.sv
// Bench for dac_spi_transmisor: decodes the SPI line as a DAC would and compares frames,
// timing and status pulses against an arithmetic model of the sample conversion.
module tb_dac_spi_transmisor;
  localparam int unsigned W = 22;
  localparam int unsigned H = 2;

  logic clk = 1'b0;
  logic reset, inicio;
  logic [W-1:0] dato;
  logic listo, ocupado, perdido, CS, sclk, sdata;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dac_spi_transmisor #(.Width(W), .SHIFT(8), .DIV(H)) dut (
    .clk100MHz(clk), .reset(reset), .inicio(inicio), .dato(dato),
    .listo(listo), .ocupado(ocupado), .perdido(perdido),
    .CS(CS), .sclk(sclk), .sdata(sdata)
  );

  // Line observer: what a DAC would latch, plus timing records
  int cyc = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b1, prev_sdata = 1'b0, prev_listo = 1'b0;
  logic [15:0] sh_bits = '0;
  int nfall = 0, lowcnt = 0, hicnt = 0, rise_cyc = 0;
  logic [15:0] frames[$];
  int lowlen[$], falls[$], gaps[$], listo_dly[$];
  logic occ_after[$];
  int listo_cnt = 0, perdido_cnt = 0, idle_viol = 0, stab_viol = 0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (CS === 1'b0) begin
        if (prev_cs === 1'b1) begin
          gaps.push_back(hicnt);
          sh_bits = '0;
          nfall = 0;
          lowcnt = 0;
        end
        lowcnt++;
        if (prev_sclk === 1'b1 && sclk === 1'b0) begin
          sh_bits = {sh_bits[14:0], sdata};
          nfall++;
          if (sdata !== prev_sdata) stab_viol++;
        end
      end else begin
        if (prev_cs === 1'b0) begin
          frames.push_back(sh_bits);
          lowlen.push_back(lowcnt);
          falls.push_back(nfall);
          rise_cyc = cyc;
          hicnt = 0;
        end
        hicnt++;
        if (sclk !== 1'b1 || sdata !== 1'b0) idle_viol++;
      end
      if (listo === 1'b1) begin
        listo_cnt++;
        listo_dly.push_back(cyc - rise_cyc);
      end
      if (prev_listo === 1'b1) occ_after.push_back(ocupado);
      if (perdido === 1'b1) perdido_cnt++;
      prev_cs = CS;
      prev_sclk = sclk;
      prev_sdata = sdata;
      prev_listo = listo;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Reference: floor(dato / 2^8), clamp to [-2048, 2047], offset by 2048
  function automatic logic [15:0] model(input logic [W-1:0] d);
    int s, v;
    s = int'($signed(d));
    v = s / 256;
    if (s < 0 && (s % 256) != 0) v = v - 1;
    if (v > 2047) v = 2047;
    if (v < -2048) v = -2048;
    return 16'(v + 2048);
  endfunction

  task automatic clear_obs();
    frames.delete(); lowlen.delete(); falls.delete(); gaps.delete();
    listo_dly.delete(); occ_after.delete();
    listo_cnt = 0; perdido_cnt = 0; idle_viol = 0; stab_viol = 0;
  endtask

  task automatic send(input logic [W-1:0] d);
    @(negedge clk);
    dato = d;
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    repeat (4) @(negedge clk);
    while ((ocupado !== 1'b0 || CS !== 1'b1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    ok = (n < 3000);
  endtask

  task automatic wait_cs_low(output bit ok);
    int n = 0;
    while (CS !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 200);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    inicio = 1'b0;
    dato = '0;
    repeat (5) @(negedge clk);
    total++; if (CS !== 1'b1) begin bad++; $display("FAIL reset_cs got=%b want=1", CS); end
    total++; if (sclk !== 1'b1) begin bad++; $display("FAIL reset_sclk got=%b want=1", sclk); end
    total++; if (sdata !== 1'b0) begin bad++; $display("FAIL reset_sdata got=%b want=0", sdata); end
    total++; if (listo !== 1'b0) begin bad++; $display("FAIL reset_listo got=%b want=0", listo); end
    total++; if (ocupado !== 1'b0) begin bad++; $display("FAIL reset_ocupado got=%b want=0", ocupado); end
    total++; if (perdido !== 1'b0) begin bad++; $display("FAIL reset_perdido got=%b want=0", perdido); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    clear_obs();
    send('0);
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout got=busy want=idle"); end
    total++; if (frames.size() != 1) begin bad++; $display("FAIL single_nframes got=%0d want=1", frames.size()); end
    if (frames.size() > 0) begin
      total++; if (frames[0] !== 16'h0800) begin bad++; $display("FAIL single_frame got=%h want=0800", frames[0]); end
      total++; if (lowlen[0] != 32 * H) begin bad++; $display("FAIL single_cs_low got=%0d want=%0d", lowlen[0], 32 * H); end
      total++; if (falls[0] != 16) begin bad++; $display("FAIL single_falls got=%0d want=16", falls[0]); end
    end
    total++; if (listo_cnt != 1) begin bad++; $display("FAIL single_listo_cnt got=%0d want=1", listo_cnt); end
    if (listo_dly.size() > 0) begin
      total++; if (listo_dly[0] != 2 * H - 1) begin bad++; $display("FAIL single_listo_pos got=%0d want=%0d", listo_dly[0], 2 * H - 1); end
    end
    if (occ_after.size() > 0) begin
      total++; if (occ_after[0] !== 1'b0) begin bad++; $display("FAIL single_ocupado_after got=%b want=0", occ_after[0]); end
    end
    total++; if (idle_viol != 0) begin bad++; $display("FAIL single_idle_lines got=%0d want=0", idle_viol); end
    total++; if (stab_viol != 0) begin bad++; $display("FAIL single_sdata_stable got=%0d want=0", stab_viol); end
  endtask

  task automatic test_codes();
    logic [W-1:0] d;
    logic [W-1:0] tbl[4];
    bit ok;
    tbl[0] = 22'sd256;
    tbl[1] = 22'h0FFFFF;
    tbl[2] = 22'h200000;
    tbl[3] = W'(-256);
    for (int i = 0; i < 16; i++) begin
      if (i < 4) d = tbl[i];
      else if (i % 2 == 0) d = W'($urandom);
      else d = W'(int'($urandom_range(0, 1200000)) - 600000);
      clear_obs();
      send(d);
      wait_idle(ok);
      total++;
      if (!ok || frames.size() != 1 || frames[0] !== model(d)) begin
        bad++;
        $display("FAIL code_%0d dato=%h got=%h n=%0d want=%h", i, d,
                 (frames.size() > 0) ? frames[0] : 16'hxxxx, frames.size(), model(d));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] x, a;
    bit ok;
    x = W'($urandom);
    a = W'(int'($urandom_range(0, 800000)) - 400000);
    clear_obs();
    send(x);
    wait_cs_low(ok);
    repeat (20) @(negedge clk);
    send(a);
    wait_idle(ok);
    total++; if (frames.size() != 2) begin bad++; $display("FAIL b2b_nframes got=%0d want=2", frames.size()); end
    if (frames.size() == 2) begin
      total++; if (frames[0] !== model(x)) begin bad++; $display("FAIL b2b_first got=%h want=%h", frames[0], model(x)); end
      total++; if (frames[1] !== model(a)) begin bad++; $display("FAIL b2b_second got=%h want=%h", frames[1], model(a)); end
      total++; if (lowlen[1] != 32 * H) begin bad++; $display("FAIL b2b_cs_low got=%0d want=%0d", lowlen[1], 32 * H); end
    end
    if (gaps.size() == 2) begin
      total++; if (gaps[1] != 2 * H) begin bad++; $display("FAIL b2b_gap got=%0d want=%0d", gaps[1], 2 * H); end
    end
    total++; if (listo_cnt != 2) begin bad++; $display("FAIL b2b_listo got=%0d want=2", listo_cnt); end
    total++; if (perdido_cnt != 0) begin bad++; $display("FAIL b2b_perdido got=%0d want=0", perdido_cnt); end
    if (occ_after.size() == 2) begin
      total++; if (occ_after[0] !== 1'b1 || occ_after[1] !== 1'b0) begin
        bad++; $display("FAIL b2b_ocupado got=%b%b want=10", occ_after[0], occ_after[1]);
      end
    end
  endtask

  task automatic test_overrun();
    logic [W-1:0] x, a, b;
    bit ok;
    x = 22'h012345;
    a = W'($urandom);
    b = W'(int'($urandom_range(0, 400000)) - 200000);
    clear_obs();
    send(x);
    wait_cs_low(ok);
    repeat (10) @(negedge clk);
    send(a);
    repeat (10) @(negedge clk);
    dato = b;
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    total++; if (perdido !== 1'b1) begin bad++; $display("FAIL overrun_pulse got=%b want=1", perdido); end
    @(negedge clk);
    total++; if (perdido !== 1'b0) begin bad++; $display("FAIL overrun_pulse_end got=%b want=0", perdido); end
    wait_idle(ok);
    total++; if (perdido_cnt != 1) begin bad++; $display("FAIL overrun_count got=%0d want=1", perdido_cnt); end
    total++; if (frames.size() != 2) begin bad++; $display("FAIL overrun_nframes got=%0d want=2", frames.size()); end
    if (frames.size() == 2) begin
      total++; if (frames[0] !== model(x)) begin bad++; $display("FAIL overrun_first got=%h want=%h", frames[0], model(x)); end
      total++; if (frames[1] !== model(b)) begin bad++; $display("FAIL overrun_second got=%h want=%h", frames[1], model(b)); end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] x, y;
    bit ok;
    int n = 0;
    x = W'($urandom);
    y = W'(int'($urandom_range(0, 1000000)) - 500000);
    clear_obs();
    send(x);
    wait_cs_low(ok);
    send(W'($urandom));
    while (nfall < 8 && n < 500) begin
      @(negedge clk);
      n++;
    end
    total++; if (n >= 500) begin bad++; $display("FAIL midreset_reach_bit7 got=%0d falls want=8", nfall); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (CS !== 1'b1) begin bad++; $display("FAIL midreset_cs got=%b want=1", CS); end
    reset = 1'b0;
    repeat (30) @(negedge clk);
    total++; if (CS !== 1'b1 || ocupado !== 1'b0) begin
      bad++; $display("FAIL midreset_buffer_discarded got=CS%b/ocupado%b want=CS1/ocupado0", CS, ocupado);
    end
    total++; if (listo_cnt != 0) begin bad++; $display("FAIL midreset_listo got=%0d want=0", listo_cnt); end
    clear_obs();
    send(y);
    wait_idle(ok);
    total++; if (frames.size() != 1) begin bad++; $display("FAIL midreset_nframes got=%0d want=1", frames.size()); end
    if (frames.size() == 1) begin
      total++; if (frames[0] !== model(y)) begin bad++; $display("FAIL midreset_frame got=%h want=%h", frames[0], model(y)); end
      total++; if (falls[0] != 16 || lowlen[0] != 32 * H) begin
        bad++; $display("FAIL midreset_full_frame got=%0d falls/%0d low want=16/%0d", falls[0], lowlen[0], 32 * H);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_codes();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
